product_accumulator: RTL and testbench
======================================

# product_accumulator

Sequential accumulate stage that sits directly downstream of the 4x4 `multiplication` block and consumes its 8-bit `Product`. Under a valid/ready handshake it sums a programmed count of products into a wider accumulator, which turns the combinational multiplier into a dot-product/MAC datapath. It presents the finished sum with its own valid/ready handshake and a sticky overflow flag.

## Interface
- `PROD_W`, 8: width of the incoming product (matches multiplier `Product`).
- `ACC_W`, 16: accumulator and sum width; must be >= `PROD_W`.
- `CNT_W`, 4: width of the length field; up to 2^CNT_W-1 products per run.

- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `start`  input  1  one-cycle request to begin a run; sampled only in IDLE.
- `len`  input  CNT_W  number of products to accumulate; sampled with `start`.
- `prod`  input  PROD_W  product from the multiplier; treated as unsigned.
- `prod_valid`  input  1  `prod` is valid this cycle.
- `prod_ready`  output  1  block accepts `prod` this cycle.
- `sum`  output  ACC_W  accumulated result; stable while `sum_valid` is high.
- `sum_valid`  output  1  `sum` is final.
- `sum_ready`  input  1  downstream takes `sum`.
- `overflow`  output  1  sticky; set if any addition carried out of ACC_W during the run.
- `busy`  output  1  high in ACCUM and DONE.

## Operation
- FSM states: IDLE, ACCUM, DONE.
- IDLE: `prod_ready`=0, `sum_valid`=0. When `start`=1: acc<=0, overflow<=0, remaining<=`len`. If `len`==0, go to DONE; otherwise go to ACCUM.
- ACCUM: `prod_ready`=1. A transfer occurs when `prod_valid && prod_ready`. On each transfer, acc<=acc+zero-extended `prod`, computed in ACC_W+1 bits; the low ACC_W bits are kept, so the result wraps modulo 2^ACC_W. If the carry bit is 1, overflow<=1. remaining decrements on each transfer. The transfer that takes remaining from 1 to 0 moves the FSM to DONE.
- No transfer (`prod_valid`=0): acc and remaining hold, and the state stays ACCUM. Bubbles are allowed indefinitely.
- DONE: `sum_valid`=1 and `sum`=acc. When `sum_ready`=1, go to IDLE. acc is not cleared, so `sum` keeps its last value.
- `start` is ignored in ACCUM and DONE. `len` is ignored except in IDLE when `start` is high.
- `prod` values offered while in IDLE or DONE are not consumed, because `prod_ready`=0.
- `sum` is driven continuously from acc.

## Timing
- Reset: state=IDLE, acc=0, remaining=0, and on the next edge `sum`=0, `sum_valid`=0, `prod_ready`=0, `overflow`=0, `busy`=0. Reset overrides all other inputs in the same cycle.
- Reset during ACCUM or DONE aborts the run. No partial sum is presented.
- `start` in cycle t: ACCUM (or DONE if `len`=0) from cycle t+1. `prod_ready` is first high in t+1.
- Throughput is one product per cycle while `prod_valid` is held high.
- Latency: `sum_valid` rises in the cycle after the last accepted product. A run of N back-to-back products therefore has `start` at t and `sum_valid` at t+N+1.
- `len`=0: `sum_valid`=1 at t+1 with `sum`=0 and `overflow`=0.
- `sum_valid` is held high until it is accepted. The earliest next `start` is accepted the cycle after the `sum_ready` handshake.
- All outputs are registered or decoded from registered state only. There is no combinational path from inputs to outputs.

## Test plan
- Default params, `len`=5, products 6,15,15,18,36 (the multiplier's 3x2, 5x3, 15x1, 9x2, 6x6) back-to-back, `sum_ready`=1 -> `sum`=90 and `sum_valid` 6 cycles after `start`, `overflow`=0, FSM back in IDLE the following cycle.
- `len`=3 with products 225,225,225 and `prod_valid` dropped for 2 cycles between each product -> `sum`=675, exactly 3 transfers counted, `prod_ready` high throughout ACCUM.
- `ACC_W`=9, `len`=3, products 225,225,225 -> `sum`=163 (675 mod 512), `overflow`=1. The next run with products 1,1 -> `sum`=2, `overflow`=0.
- `len`=0 -> `sum_valid` the next cycle with `sum`=0. Then `len`=2, products 6,15, with `sum_ready` held low 5 cycles -> `sum`=21 stays stable, and a `start` pulse issued during DONE is ignored.
- Assert `rst` for one cycle after 2 of 4 products (6,15) -> all outputs return to reset values. A fresh run with `len`=1, product 36 -> `sum`=36.
- Pulse `start` with `len`=7 during ACCUM of a `len`=2 run with products 9,9 -> the run completes after 2 products with `sum`=18, and remaining is not reloaded.

Source files
------------

// File: rtl/product_accumulator.sv
// Accumulates a programmed count of unsigned multiplier products into a wider sum,
// with valid/ready handshakes on both sides and a sticky carry-out flag.
//
// state | meaning
// IDLE  | waiting for start; no product accepted, no sum presented
// ACCUM | accepting products until the programmed count is consumed
// DONE  | sum final and presented until downstream takes it
module product_accumulator #(
  parameter int PROD_W = 8,
  parameter int ACC_W  = 16,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  len,
  input  logic [PROD_W-1:0] prod,
  input  logic              prod_valid,
  output logic              prod_ready,
  output logic [ACC_W-1:0]  sum,
  output logic              sum_valid,
  input  logic              sum_ready,
  output logic              overflow,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] remaining;
  logic [ACC_W:0]   add_full;

  // One extra bit captures the carry out of the accumulator width.
  assign add_full = {1'b0, acc} + (ACC_W+1)'(prod);
  assign sum      = acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      acc        <= '0;
      remaining  <= '0;
      overflow   <= 1'b0;
      prod_ready <= 1'b0;
      sum_valid  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            acc       <= '0;
            overflow  <= 1'b0;
            remaining <= len;
            busy      <= 1'b1;
            if (len == '0) begin
              state     <= DONE;
              sum_valid <= 1'b1;
            end else begin
              state      <= ACCUM;
              prod_ready <= 1'b1;
            end
          end
        end
        ACCUM: begin
          // prod_ready is high for the whole of ACCUM, so prod_valid alone marks a transfer.
          if (prod_valid) begin
            acc       <= add_full[ACC_W-1:0];
            remaining <= remaining - 1'b1;
            if (add_full[ACC_W]) overflow <= 1'b1;
            if (remaining == CNT_W'(1)) begin
              state      <= DONE;
              prod_ready <= 1'b0;
              sum_valid  <= 1'b1;
            end
          end
        end
        DONE: begin
          if (sum_ready) begin
            state     <= IDLE;
            sum_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          prod_ready <= 1'b0;
          sum_valid  <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_product_accumulator.sv
// Directed bench for product_accumulator: a 16-bit and a 9-bit accumulator share one
// stimulus stream so wrap/overflow behaviour is checked alongside the wide result.
module tb_product_accumulator;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] len;
  logic [7:0] prod;
  logic       prod_valid;
  logic       sum_ready;

  logic        prod_ready, sum_valid, overflow, busy;
  logic [15:0] sum;
  logic        prod_ready9, sum_valid9, overflow9, busy9;
  logic [8:0]  sum9;

  int checks = 0;
  int fails  = 0;
  int xfers  = 0;

  product_accumulator #(.PROD_W(8), .ACC_W(16), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .prod(prod),
    .prod_valid(prod_valid), .prod_ready(prod_ready), .sum(sum),
    .sum_valid(sum_valid), .sum_ready(sum_ready), .overflow(overflow), .busy(busy)
  );

  product_accumulator #(.PROD_W(8), .ACC_W(9), .CNT_W(4)) dut9 (
    .clk(clk), .rst(rst), .start(start), .len(len), .prod(prod),
    .prod_valid(prod_valid), .prod_ready(prod_ready9), .sum(sum9),
    .sum_valid(sum_valid9), .sum_ready(sum_ready), .overflow(overflow9), .busy(busy9)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (prod_valid && prod_ready) xfers++;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  // Advance one clock; inputs set before the call are sampled by this edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; len = 4'd0; prod = 8'd0; prod_valid = 1'b0; sum_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;
    checks++; if (sum !== 16'd0) begin fails++; $display("FAIL reset_sum got %0d want 0", sum); end
    checks++; if ({sum_valid, prod_ready, overflow, busy} !== 4'b0000) begin fails++; $display("FAIL reset_flags got %b want 0000", {sum_valid, prod_ready, overflow, busy}); end
    checks++; if ({sum9, sum_valid9, prod_ready9, overflow9, busy9} !== 13'd0) begin fails++; $display("FAIL reset_dut9 got %h want 0", {sum9, sum_valid9, prod_ready9, overflow9, busy9}); end
  endtask

  task automatic test_dot_product();
    logic [7:0] p [5];
    p[0] = 8'd6; p[1] = 8'd15; p[2] = 8'd15; p[3] = 8'd18; p[4] = 8'd36;
    xfers = 0;
    start = 1'b1; len = 4'd5;
    tick();
    start = 1'b0;
    checks++; if ({prod_ready, busy, sum_valid} !== 3'b110) begin fails++; $display("FAIL dot_enter_accum got %b want 110", {prod_ready, busy, sum_valid}); end
    for (int i = 0; i < 5; i++) begin
      prod = p[i]; prod_valid = 1'b1;
      tick();
      if (i < 4) begin
        checks++; if (sum_valid !== 1'b0) begin fails++; $display("FAIL dot_early_valid cycle %0d got %b want 0", i + 2, sum_valid); end
      end
    end
    prod_valid = 1'b0;
    checks++; if (sum_valid !== 1'b1) begin fails++; $display("FAIL dot_latency got sum_valid=%b want 1 at start+6", sum_valid); end
    checks++; if (sum !== 16'd90) begin fails++; $display("FAIL dot_sum got %0d want 90", sum); end
    checks++; if (overflow !== 1'b0) begin fails++; $display("FAIL dot_overflow got %b want 0", overflow); end
    checks++; if (prod_ready !== 1'b0) begin fails++; $display("FAIL dot_ready_done got %b want 0", prod_ready); end
    checks++; if (xfers !== 5) begin fails++; $display("FAIL dot_xfers got %0d want 5", xfers); end
    tick();
    checks++; if ({sum_valid, busy} !== 2'b00) begin fails++; $display("FAIL dot_back_idle got %b want 00", {sum_valid, busy}); end
    checks++; if (sum !== 16'd90) begin fails++; $display("FAIL dot_sum_held got %0d want 90", sum); end
  endtask

  task automatic test_bubbles_overflow();
    xfers = 0;
    start = 1'b1; len = 4'd3;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      prod = 8'd225; prod_valid = 1'b1;
      tick();
      if (i < 2) begin
        prod_valid = 1'b0; prod = 8'd77;
        for (int b = 0; b < 2; b++) begin
          checks++; if (prod_ready !== 1'b1) begin fails++; $display("FAIL bub_ready got %b want 1", prod_ready); end
          tick();
        end
      end
    end
    prod_valid = 1'b0;
    checks++; if (sum_valid !== 1'b1) begin fails++; $display("FAIL bub_valid got %b want 1", sum_valid); end
    checks++; if (sum !== 16'd675) begin fails++; $display("FAIL bub_sum got %0d want 675", sum); end
    checks++; if (overflow !== 1'b0) begin fails++; $display("FAIL bub_ovf16 got %b want 0", overflow); end
    checks++; if (xfers !== 3) begin fails++; $display("FAIL bub_xfers got %0d want 3", xfers); end
    checks++; if (sum9 !== 9'd163) begin fails++; $display("FAIL wrap_sum9 got %0d want 163", sum9); end
    checks++; if (overflow9 !== 1'b1) begin fails++; $display("FAIL wrap_ovf9 got %b want 1", overflow9); end
    tick();
    start = 1'b1; len = 4'd2;
    tick();
    start = 1'b0;
    checks++; if (overflow9 !== 1'b0) begin fails++; $display("FAIL ovf9_cleared got %b want 0", overflow9); end
    prod = 8'd1; prod_valid = 1'b1;
    tick(); tick();
    prod_valid = 1'b0;
    checks++; if ({sum_valid9, sum9} !== {1'b1, 9'd2}) begin fails++; $display("FAIL rerun_sum9 got %0d valid %b want 2 valid 1", sum9, sum_valid9); end
    checks++; if (overflow9 !== 1'b0) begin fails++; $display("FAIL rerun_ovf9 got %b want 0", overflow9); end
    tick();
  endtask

  task automatic test_len_zero_backpressure();
    start = 1'b1; len = 4'd0;
    tick();
    start = 1'b0;
    checks++; if ({sum_valid, busy, prod_ready} !== 3'b110) begin fails++; $display("FAIL len0_flags got %b want 110", {sum_valid, busy, prod_ready}); end
    checks++; if ({sum, overflow} !== 17'd0) begin fails++; $display("FAIL len0_sum got %0d ovf %b want 0 ovf 0", sum, overflow); end
    tick();
    sum_ready = 1'b0;
    start = 1'b1; len = 4'd2;
    tick();
    start = 1'b0;
    prod = 8'd6; prod_valid = 1'b1; tick();
    prod = 8'd15; tick();
    prod = 8'd99;
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin start = 1'b1; len = 4'd7; end
      else start = 1'b0;
      checks++; if ({sum_valid, sum} !== {1'b1, 16'd21}) begin fails++; $display("FAIL bp_hold cycle %0d got sum %0d valid %b want 21 valid 1", i, sum, sum_valid); end
      tick();
    end
    start = 1'b0;
    checks++; if ({sum_valid, sum} !== {1'b1, 16'd21}) begin fails++; $display("FAIL bp_start_ignored got sum %0d valid %b want 21 valid 1", sum, sum_valid); end
    prod_valid = 1'b0;
    sum_ready = 1'b1;
    tick();
    checks++; if ({sum_valid, busy, prod_ready} !== 3'b000) begin fails++; $display("FAIL bp_release got %b want 000", {sum_valid, busy, prod_ready}); end
  endtask

  task automatic test_reset_abort();
    start = 1'b1; len = 4'd4;
    tick();
    start = 1'b0;
    prod = 8'd6; prod_valid = 1'b1; tick();
    prod = 8'd15; tick();
    prod = 8'd18; rst = 1'b1;
    tick();
    rst = 1'b0; prod_valid = 1'b0;
    checks++; if (sum !== 16'd0) begin fails++; $display("FAIL abort_sum got %0d want 0", sum); end
    checks++; if ({sum_valid, prod_ready, overflow, busy} !== 4'b0000) begin fails++; $display("FAIL abort_flags got %b want 0000", {sum_valid, prod_ready, overflow, busy}); end
    start = 1'b1; len = 4'd1;
    tick();
    start = 1'b0;
    prod = 8'd36; prod_valid = 1'b1;
    tick();
    prod_valid = 1'b0;
    checks++; if ({sum_valid, sum} !== {1'b1, 16'd36}) begin fails++; $display("FAIL fresh_run got sum %0d valid %b want 36 valid 1", sum, sum_valid); end
    tick();
  endtask

  task automatic test_start_in_accum();
    xfers = 0;
    start = 1'b1; len = 4'd2;
    tick();
    prod = 8'd9; prod_valid = 1'b1; start = 1'b1; len = 4'd7;
    tick();
    start = 1'b0; len = 4'd0;
    tick();
    prod_valid = 1'b0;
    checks++; if ({sum_valid, sum} !== {1'b1, 16'd18}) begin fails++; $display("FAIL noreload_sum got sum %0d valid %b want 18 valid 1", sum, sum_valid); end
    checks++; if (xfers !== 2) begin fails++; $display("FAIL noreload_xfers got %0d want 2", xfers); end
    tick();
    checks++; if ({sum_valid, busy} !== 2'b00) begin fails++; $display("FAIL noreload_idle got %b want 00", {sum_valid, busy}); end
  endtask

  initial begin
    test_reset();
    test_dot_product();
    test_bubbles_overflow();
    test_len_zero_backpressure();
    test_reset_abort();
    test_start_in_accum();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
